// File: rtl/exe_muldiv_pkg.sv
// rtl/exe_muldiv_pkg.sv - shared op encodings, FSM states and iteration count for exe_muldiv
package muldiv_pkg;

  // Default operand width; the unit retires one result bit per iteration.
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } state_e;

endpackage

// File: rtl/exe_muldiv_if.sv
// rtl/exe_muldiv_if.sv - ID/EXE-side request, MTHI/MTLO and HI/LO result bundle for exe_muldiv
interface exe_muldiv_if #(
  parameter int WIDTH = muldiv_pkg::ITER
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/exe_muldiv_signfix.sv
// rtl/exe_muldiv_signfix.sv - applies result signs to the unsigned datapath output and the divide-by-zero override
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic               is_div_i,
  input  logic               neg_res_i,
  input  logic               neg_rem_i,
  input  logic               div0_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic [WIDTH-1:0]   raw_a_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res_i ? (~prod_i + 1'b1) : prod_i;
  assign quo_fix  = neg_res_i ? (~quo_i + 1'b1) : quo_i;
  assign rem_fix  = neg_rem_i ? (~rem_i + 1'b1) : rem_i;

  always_comb begin
    hi_o = prod_fix[2*WIDTH-1:WIDTH];
    lo_o = prod_fix[WIDTH-1:0];
    if (is_div_i) begin
      // Divide by zero returns the raw dividend in HI regardless of signedness.
      if (div0_i) begin
        hi_o = raw_a_i;
        lo_o = '1;
      end else begin
        hi_o = rem_fix;
        lo_o = quo_fix;
      end
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with hazard stall request
// Optional MULDIV_DIV0_FAST_EN: divide by zero bypasses CALC and finishes two cycles after start.
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input logic         clk,
  input logic         rst,
  exe_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;

  logic               op_div, op_signed, a_neg, b_neg, launch;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH:0]   mul_next, div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = op_signed & bus.src_a[WIDTH-1];
  assign b_neg     = op_signed & bus.src_b[WIDTH-1];
  assign abs_a     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign abs_b     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  assign launch    = bus.start & ~bus.flush;

  // Multiply: upper half accumulates the multiplicand, lower half shifts the multiplier out.
  assign mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend in / quotient out.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div_i  (is_div_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .div0_i    (div0_q),
    .prod_i    (acc_q[2*WIDTH-1:0]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .raw_a_i   (raw_a_q),
    .hi_o      (fix_hi),
    .lo_o      (fix_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (launch) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          is_div_d  = op_div;
          raw_a_d   = bus.src_a;
          div0_d    = op_div && (bus.src_b == '0);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = op_div & a_neg;
          opnd_d    = op_div ? abs_b : abs_a;
          acc_d     = {{(WIDTH+1){1'b0}}, (op_div ? abs_a : abs_b)};
`ifdef MULDIV_DIV0_FAST_EN
          if (op_div && (bus.src_b == '0)) state_d = ST_SIGN;
`else
`endif
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.stall_req = (bus.start & (state_q == ST_IDLE) & ~bus.flush) | bus.busy;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - self-checking bench for exe_muldiv: arithmetic reference model plus directed vectors
module tb_exe_muldiv;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  exe_muldiv_if #(.WIDTH(32)) bus ();

  exe_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result: {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    logic [31:0]     q, r;
    case (op)
      2'b00: begin sa = longint'($signed(a)); sb = longint'($signed(b)); return 64'(sa * sb); end
      2'b01: begin ua = 64'(a); ub = 64'(b); return ua * ub; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a); ib = $signed(b);
        q = 32'(ia / ib); r = 32'(ia % ib);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_DIV0_FAST_EN
    if (op[1] && b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Reference: m_left = edges remaining until the result lands in HI/LO
  int          m_left;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  logic        m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left == 0) begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
        if (bus.start && !bus.flush) begin
          {m_rhi, m_rlo} = model(bus.op, bus.src_a, bus.src_b);
          m_left = latency(bus.op, bus.src_b);
        end
      end else if (bus.flush) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_rhi; m_lo = m_rlo; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
    check("cyc_stall", 64'(bus.stall_req),
          64'((m_left != 0) || (bus.start && !bus.flush)));
    check("cyc_done", 64'(bus.done), 64'(m_done));
    check("cyc_hi", 64'(bus.hi), 64'(m_hi));
    check("cyc_lo", 64'(bus.lo), 64'(m_lo));
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    int n, st;
    bit seen;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; st = 0; seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1;
      else if (bus.stall_req) st++;
    end
    check({nm, "_done_cycle"}, 64'(n), 64'(ecyc));
    check({nm, "_stall_cycles"}, 64'(st), 64'(ecyc - 1));
    check({nm, "_hi"}, 64'(bus.hi), 64'(eh));
    check({nm, "_lo"}, 64'(bus.lo), 64'(el));
    #1;
  endtask

  int div0_cyc;
  bit saw_done;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
`ifdef MULDIV_DIV0_FAST_EN
    div0_cyc = 2;
`else
    div0_cyc = 34;
`endif
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);

    check("model_multu", model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_mult", model(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    check("model_div_neg", model(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_div_ovf", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
    run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, div0_cyc);
    run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, div0_cyc);
    run_op("div_mixed", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 34);

    // MTHI/MTLO preload, then flushed MULT
    @(posedge clk); #1;
    bus.hi_we = 1; bus.wdata = 32'h11;
    @(posedge clk); #1;
    bus.hi_we = 0; bus.lo_we = 1; bus.wdata = 32'h22;
    @(posedge clk); #1;
    bus.lo_we = 0;
    check("preload_hi", 64'(bus.hi), 64'h11);
    check("preload_lo", 64'(bus.lo), 64'h22);
    bus.start = 1; bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0;
    @(negedge clk);
    check("flush_busy_c11", 64'(bus.busy), 64'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'h11);
    check("flush_lo", 64'(bus.lo), 64'h22);

    // MTHI while busy is ignored
    #1;
    bus.start = 1; bus.op = 2'b00; bus.src_a = 32'd2; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (4) @(posedge clk);
    #1;
    bus.hi_we = 1; bus.wdata = 32'h99;
    @(posedge clk); #1;
    bus.hi_we = 0;
    @(negedge clk);
    check("busy_hi_we_ignored", 64'(bus.hi), 64'h11);
    saw_done = 0;
    for (int i = 0; i < 60 && !saw_done; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("mult_after_hi_we_done", 64'(saw_done), 64'd1);
    check("mult_after_hi_we_hi", 64'(bus.hi), 64'd0);
    check("mult_after_hi_we_lo", 64'(bus.lo), 64'd6);

    // Asynchronous reset mid-CALC
    #1;
    bus.start = 1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_stall", 64'(bus.stall_req), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    run_op("multu_after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 34);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
